// File: rtl/goe_pkg.sv
// goe_pkg: shared word-type codes, PHV field positions, metadata FIFO
// geometry and the transmit FSM state type used by goe_tx.
package goe_pkg;

   localparam int DATA_W = 134;
   localparam int PHV_W  = 1024;

   // Word type codes carried in data word bits [133:132]
   localparam logic [1:0] WT_HEAD = 2'b01;
   localparam logic [1:0] WT_MID  = 2'b11;
   localparam logic [1:0] WT_TAIL = 2'b10;

   // Head-word payload byte replaced by the PHV output port
   localparam int HEAD_PORT_HI = 127;
   localparam int HEAD_PORT_LO = 120;

   // PHV fields kept per packet
   localparam int PHV_DROP_BIT = 1023;
   localparam int PHV_PORT_HI  = 1015;
   localparam int PHV_PORT_LO  = 1008;

   // Status and PHV FIFOs: 16 entries, almost-full at 14
   localparam int META_FIFO_AW   = 4;
   localparam int META_ALF_LEVEL = 14;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECIDE,
      ST_SEND,
      ST_DROP
   } goe_state_e;

   typedef struct packed {
      logic       drop;
      logic [7:0] port;
   } phv_meta_t;

   function automatic logic [1:0] word_type(input logic [DATA_W-1:0] w);
      return w[DATA_W-1 -: 2];
   endfunction

endpackage

// File: rtl/goe_sync_fifo.sv
// goe_sync_fifo: single-clock show-ahead FIFO with occupancy count.
// Simultaneous push and pop are allowed, including push while full when a
// pop frees the slot in the same cycle. A refused write raises o_ovf for
// that cycle; the owner keeps the sticky flag.
module goe_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count,
   output logic             o_ovf
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_pop  = i_rd_en && !o_empty;
   assign w_push = i_wr_en && (!o_full || w_pop);
   assign o_ovf  = i_wr_en && !w_push;

   // Pointer and occupancy bookkeeping
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write
   // NOTE: the array has no reset; emptiness is defined by the pointers and
   // count, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule

// File: rtl/goe_tx.sv
// goe_tx: buffers packets from the pgm, pairs each with its PHV metadata and
// end-of-packet status, then transmits (port byte patched into the head) or
// discards it. Optional statistics counters under macro GOE_TX_STATS_EN.
module goe_tx
   import goe_pkg::*;
#(
   parameter logic [7:0] LMID      = 8'd7,
   parameter int         DFIFO_AW  = 8,
   parameter int         AF_MARGIN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [133:0]       in_goe_data,
   input  logic               in_goe_data_wr,
   input  logic               in_goe_valid_wr,
   input  logic               in_goe_valid,
   output logic               out_goe_alf,
   input  logic [1023:0]      in_goe_phv,
   input  logic               in_goe_phv_wr,
   output logic               out_goe_phv_alf,
   output logic [133:0]       pktout_data,
   output logic               pktout_data_wr,
   output logic               pktout_data_valid,
   output logic               pktout_data_valid_wr,
   input  logic               in_pktout_alf,
   output logic [31:0]        out_goe_pkt_cnt,
   output logic [31:0]        out_goe_drop_cnt
);

   localparam int DFIFO_DEPTH = 1 << DFIFO_AW;
   localparam int AF_LEVEL    = DFIFO_DEPTH - AF_MARGIN;

   goe_state_e            r_state;
   goe_state_e            w_state_nxt;
   logic                  r_in_sync;
   logic                  r_ovf;

   logic                  w_d_wr;
   logic                  w_s_wr;
   logic                  w_d_pop;
   logic                  w_xmit;
   logic                  w_tail_pop;

   logic [DATA_W-1:0]     w_d_head;
   logic                  w_d_empty;
   logic                  w_d_full;
   logic [DFIFO_AW:0]     w_d_count;
   logic                  w_d_ovf;

   logic                  w_s_head;
   logic                  w_s_empty;
   logic                  w_s_full;
   logic [META_FIFO_AW:0] w_s_count;
   logic                  w_s_ovf;

   phv_meta_t             w_phv_in;
   phv_meta_t             w_p_head;
   logic                  w_p_empty;
   logic                  w_p_full;
   logic [META_FIFO_AW:0] w_p_count;
   logic                  w_p_ovf;

   logic [DATA_W-1:0]     w_tx_word;

   logic [133:0]          r_pktout_data;
   logic                  r_pktout_data_wr;
   logic                  r_pktout_valid;
   logic                  r_pktout_valid_wr;

   // Words of a packet cut by reset are ignored until the next head arrives
   assign w_d_wr = in_goe_data_wr && (r_in_sync || (word_type(in_goe_data) == WT_HEAD));
   assign w_s_wr = in_goe_valid_wr && r_in_sync;

   assign w_phv_in.drop = in_goe_phv[PHV_DROP_BIT];
   assign w_phv_in.port = in_goe_phv[PHV_PORT_HI:PHV_PORT_LO];

   goe_sync_fifo #(.WIDTH(DATA_W), .AW(DFIFO_AW)) u_data_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_d_wr),
      .i_wr_data (in_goe_data),
      .i_rd_en   (w_d_pop),
      .o_rd_data (w_d_head),
      .o_full    (w_d_full),
      .o_empty   (w_d_empty),
      .o_count   (w_d_count),
      .o_ovf     (w_d_ovf)
   );

   goe_sync_fifo #(.WIDTH(1), .AW(META_FIFO_AW)) u_stat_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_s_wr),
      .i_wr_data (in_goe_valid),
      .i_rd_en   (w_tail_pop),
      .o_rd_data (w_s_head),
      .o_full    (w_s_full),
      .o_empty   (w_s_empty),
      .o_count   (w_s_count),
      .o_ovf     (w_s_ovf)
   );

   goe_sync_fifo #(.WIDTH($bits(phv_meta_t)), .AW(META_FIFO_AW)) u_phv_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (in_goe_phv_wr),
      .i_wr_data (w_phv_in),
      .i_rd_en   (w_tail_pop),
      .o_rd_data (w_p_head),
      .o_full    (w_p_full),
      .o_empty   (w_p_empty),
      .o_count   (w_p_count),
      .o_ovf     (w_p_ovf)
   );

   assign out_goe_alf     = (int'(w_d_count) > AF_LEVEL) || (int'(w_s_count) >= META_ALF_LEVEL);
   assign out_goe_phv_alf = (int'(w_p_count) >= META_ALF_LEVEL);

   // Input resynchronisation flag: set by the first head after reset
   always_ff @(posedge clk) begin
      if (rst)
         r_in_sync <= 1'b0;
      else if (in_goe_data_wr && (word_type(in_goe_data) == WT_HEAD))
         r_in_sync <= 1'b1;
   end

   // Sticky record of any write refused by a full FIFO
   always_ff @(posedge clk) begin
      if (rst)
         r_ovf <= 1'b0;
      else if (w_d_ovf || w_s_ovf || w_p_ovf)
         r_ovf <= 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state: wait for metadata, decide once, stream until the tail
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (!w_p_empty && !w_s_empty) w_state_nxt = ST_DECIDE;
         ST_DECIDE: w_state_nxt = (!w_p_head.drop && w_s_head) ? ST_SEND : ST_DROP;
         ST_SEND,
         ST_DROP:   if (w_tail_pop) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: data pop (held by downstream backpressure only in SEND)
   always_comb begin
      w_d_pop = 1'b0;
      w_xmit  = 1'b0;
      case (r_state)
         ST_SEND: begin
            w_d_pop = !w_d_empty && !in_pktout_alf;
            w_xmit  = w_d_pop;
         end
         ST_DROP: w_d_pop = !w_d_empty;
         default: ;
      endcase
      w_tail_pop = w_d_pop && (word_type(w_d_head) == WT_TAIL);
   end

   // Head word gets the PHV output port in its top payload byte
   always_comb begin
      w_tx_word = w_d_head;
      if (word_type(w_d_head) == WT_HEAD)
         w_tx_word[HEAD_PORT_HI:HEAD_PORT_LO] = w_p_head.port;
   end

   // Registered transmit interface, one cycle behind the FIFO read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pktout_data     <= '0;
         r_pktout_data_wr  <= 1'b0;
         r_pktout_valid    <= 1'b0;
         r_pktout_valid_wr <= 1'b0;
      end else begin
         r_pktout_data_wr  <= w_xmit;
         r_pktout_valid    <= w_xmit && w_tail_pop;
         r_pktout_valid_wr <= w_xmit && w_tail_pop;
         if (w_xmit) r_pktout_data <= w_tx_word;
      end
   end

   assign pktout_data          = r_pktout_data;
   assign pktout_data_wr       = r_pktout_data_wr;
   assign pktout_data_valid    = r_pktout_valid;
   assign pktout_data_valid_wr = r_pktout_valid_wr;

`ifdef GOE_TX_STATS_EN
   logic [31:0] r_pkt_cnt;
   logic [31:0] r_drop_cnt;

   // Packet statistics, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_tail_pop && (r_state == ST_SEND)) r_pkt_cnt  <= r_pkt_cnt + 32'd1;
         if (w_tail_pop && (r_state == ST_DROP)) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign out_goe_pkt_cnt  = r_pkt_cnt;
   assign out_goe_drop_cnt = r_drop_cnt;
`else
   assign out_goe_pkt_cnt  = '0;
   assign out_goe_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_goe_tx.sv
// tb_goe_tx: directed self-checking bench for goe_tx.
module tb_goe_tx;

   logic          clk;
   logic          rst;
   logic [133:0]  in_goe_data;
   logic          in_goe_data_wr;
   logic          in_goe_valid_wr;
   logic          in_goe_valid;
   logic          out_goe_alf;
   logic [1023:0] in_goe_phv;
   logic          in_goe_phv_wr;
   logic          out_goe_phv_alf;
   logic [133:0]  pktout_data;
   logic          pktout_data_wr;
   logic          pktout_data_valid;
   logic          pktout_data_valid_wr;
   logic          in_pktout_alf;
   logic [31:0]   out_goe_pkt_cnt;
   logic [31:0]   out_goe_drop_cnt;

   int            errors = 0;
   int            checks = 0;
   logic [133:0]  q[$];
   int            nvalid = 0;
   logic          last_valid = 1'b0;
   int            exp_pkt = 0;
   int            exp_drop = 0;
   int            cnt0;

   goe_tx dut (
      .clk                  (clk),
      .rst                  (rst),
      .in_goe_data          (in_goe_data),
      .in_goe_data_wr       (in_goe_data_wr),
      .in_goe_valid_wr      (in_goe_valid_wr),
      .in_goe_valid         (in_goe_valid),
      .out_goe_alf          (out_goe_alf),
      .in_goe_phv           (in_goe_phv),
      .in_goe_phv_wr        (in_goe_phv_wr),
      .out_goe_phv_alf      (out_goe_phv_alf),
      .pktout_data          (pktout_data),
      .pktout_data_wr       (pktout_data_wr),
      .pktout_data_valid    (pktout_data_valid),
      .pktout_data_valid_wr (pktout_data_valid_wr),
      .in_pktout_alf        (in_pktout_alf),
      .out_goe_pkt_cnt      (out_goe_pkt_cnt),
      .out_goe_drop_cnt     (out_goe_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture transmitted words and end-of-packet pulses away from the edge
   always @(negedge clk) begin
      if (pktout_data_wr) q.push_back(pktout_data);
      if (pktout_data_valid_wr) begin
         nvalid++;
         last_valid = pktout_data_valid;
      end
   end

   function automatic int stat_exp(input int n);
`ifdef GOE_TX_STATS_EN
      return n;
`else
      return 0;
`endif
   endfunction

   function automatic logic [133:0] mk_word(input logic [1:0] t, input logic [15:0] base,
                                            input logic [15:0] idx);
      return {t, 4'h0, 8'hEE, 88'h0, base, idx};
   endfunction

   function automatic logic [1:0] type_of(input int i, input int n);
      if (i == 0)     return 2'b01;
      if (i == n - 1) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic [133:0] exp_word(input int i, input int n, input logic [15:0] base,
                                             input logic [7:0] port);
      logic [133:0] w;
      w = mk_word(type_of(i, n), base, 16'(i));
      if (i == 0) w[127:120] = port;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_phv(input logic drop, input logic [7:0] port);
      @(negedge clk);
      in_goe_phv             = '0;
      in_goe_phv[1023]       = drop;
      in_goe_phv[1015:1008]  = port;
      in_goe_phv_wr          = 1'b1;
      @(negedge clk);
      in_goe_phv_wr          = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [15:0] base, input logic good);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_goe_data     = mk_word(type_of(i, n), base, 16'(i));
         in_goe_data_wr  = 1'b1;
         in_goe_valid_wr = (i == n - 1);
         in_goe_valid    = (i == n - 1) && good;
      end
      @(negedge clk);
      in_goe_data_wr  = 1'b0;
      in_goe_valid_wr = 1'b0;
      in_goe_valid    = 1'b0;
   endtask

   task automatic clear_capture();
      @(negedge clk);
      #1;
      q.delete();
      nvalid = 0;
      last_valid = 1'b0;
   endtask

   task automatic verify_pkt(input string tag, input int n, input logic [15:0] base,
                             input logic [7:0] port);
      chk({tag, "_nwords"}, 134'(q.size()), 134'(n));
      for (int i = 0; i < n && i < q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), q[i], exp_word(i, n, base, port));
      chk({tag, "_nvalid"}, 134'(nvalid), 134'(1));
      chk({tag, "_valid"}, 134'(last_valid), 134'(1));
   endtask

   initial begin
      rst             = 1'b1;
      in_goe_data     = '0;
      in_goe_data_wr  = 1'b0;
      in_goe_valid_wr = 1'b0;
      in_goe_valid    = 1'b0;
      in_goe_phv      = '0;
      in_goe_phv_wr   = 1'b0;
      in_pktout_alf   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_data",     pktout_data, '0);
      chk("rst_wr",       134'(pktout_data_wr), 134'(0));
      chk("rst_vwr",      134'(pktout_data_valid_wr), 134'(0));
      chk("rst_alf",      134'(out_goe_alf), 134'(0));
      chk("rst_phv_alf",  134'(out_goe_phv_alf), 134'(0));
      chk("rst_pkt_cnt",  134'(out_goe_pkt_cnt), 134'(0));
      rst = 1'b0;
      clear_capture();

      // Good 3-word packet, port 8'h05
      push_phv(1'b0, 8'h05);
      send_pkt(3, 16'h0001, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      exp_pkt++;
      verify_pkt("good3", 3, 16'h0001, 8'h05);
      chk("good3_pkt_cnt", 134'(out_goe_pkt_cnt), 134'(stat_exp(exp_pkt)));
      clear_capture();

      // PHV drop on a 4-word packet
      push_phv(1'b1, 8'h09);
      send_pkt(4, 16'h0002, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      exp_drop++;
      chk("drop4_nwords",   134'(q.size()), 134'(0));
      chk("drop4_nvalid",   134'(nvalid), 134'(0));
      chk("drop4_drop_cnt", 134'(out_goe_drop_cnt), 134'(stat_exp(exp_drop)));
      clear_capture();

      // Bad status on a 2-word packet
      push_phv(1'b0, 8'h0A);
      send_pkt(2, 16'h0003, 1'b0);
      repeat (20) @(negedge clk);
      #1;
      exp_drop++;
      chk("bad2_nwords",   134'(q.size()), 134'(0));
      chk("bad2_drop_cnt", 134'(out_goe_drop_cnt), 134'(stat_exp(exp_drop)));
      clear_capture();

      // Following packet proves the dropped words were fully popped
      push_phv(1'b0, 8'h22);
      send_pkt(3, 16'h0004, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      exp_pkt++;
      verify_pkt("after_drop", 3, 16'h0004, 8'h22);
      chk("after_drop_pkt_cnt", 134'(out_goe_pkt_cnt), 134'(stat_exp(exp_pkt)));
      clear_capture();

      // Downstream backpressure for 5 cycles mid-packet
      push_phv(1'b0, 8'h03);
      send_pkt(8, 16'h0005, 1'b1);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         #1;
         if (q.size() >= 2) break;
      end
      chk("pause_started", 134'(q.size() >= 2), 134'(1));
      in_pktout_alf = 1'b1;
      cnt0 = q.size();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("pause_wr_c%0d", k), 134'(pktout_data_wr), 134'(0));
      end
      chk("pause_hold", 134'(q.size()), 134'(cnt0));
      in_pktout_alf = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      exp_pkt++;
      verify_pkt("pause8", 8, 16'h0005, 8'h03);
      clear_capture();

      // Data FIFO almost-full: 224 words -> clear, 225 words -> set
      for (int i = 0; i < 225; i++) begin
         @(negedge clk);
         if (i == 224) chk("alf_224", 134'(out_goe_alf), 134'(0));
         in_goe_data     = mk_word(type_of(i, 225), 16'h0006, 16'(i));
         in_goe_data_wr  = 1'b1;
         in_goe_valid_wr = (i == 224);
         in_goe_valid    = (i == 224);
      end
      @(negedge clk);
      chk("alf_225", 134'(out_goe_alf), 134'(1));
      in_goe_data_wr  = 1'b0;
      in_goe_valid_wr = 1'b0;
      in_goe_valid    = 1'b0;
      push_phv(1'b0, 8'h66);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (!out_goe_alf) break;
      end
      chk("alf_release", 134'(out_goe_alf), 134'(0));
      repeat (260) @(negedge clk);
      #1;
      exp_pkt++;
      chk("big_nwords", 134'(q.size()), 134'(225));
      if (q.size() == 225) begin
         chk("big_head", q[0],   exp_word(0, 225, 16'h0006, 8'h66));
         chk("big_w100", q[100], exp_word(100, 225, 16'h0006, 8'h66));
         chk("big_tail", q[224], exp_word(224, 225, 16'h0006, 8'h66));
      end
      chk("big_nvalid", 134'(nvalid), 134'(1));
      chk("big_pkt_cnt", 134'(out_goe_pkt_cnt), 134'(stat_exp(exp_pkt)));
      clear_capture();

      // PHV FIFO almost-full: 13 entries clear, 14 set
      for (int i = 0; i < 13; i++) push_phv(1'b1, 8'(i));
      #1;
      chk("phv_alf_13", 134'(out_goe_phv_alf), 134'(0));
      push_phv(1'b1, 8'h0D);
      #1;
      chk("phv_alf_14", 134'(out_goe_phv_alf), 134'(1));

      // Reset during word 2 of a 4-word packet
      push_phv(1'b0, 8'h11);
      @(negedge clk);
      in_goe_data    = mk_word(2'b01, 16'h00F0, 16'd0);
      in_goe_data_wr = 1'b1;
      @(negedge clk);
      in_goe_data    = mk_word(2'b11, 16'h00F0, 16'd1);
      rst            = 1'b1;
      @(negedge clk);
      in_goe_data_wr = 1'b0;
      #1;
      chk("mrst_data",     pktout_data, '0);
      chk("mrst_wr",       134'(pktout_data_wr), 134'(0));
      chk("mrst_alf",      134'(out_goe_alf), 134'(0));
      chk("mrst_phv_alf",  134'(out_goe_phv_alf), 134'(0));
      chk("mrst_pkt_cnt",  134'(out_goe_pkt_cnt), 134'(0));
      chk("mrst_drop_cnt", 134'(out_goe_drop_cnt), 134'(0));
      @(negedge clk);
      rst = 1'b0;
      exp_pkt  = 0;
      exp_drop = 0;
      clear_capture();
      push_phv(1'b0, 8'h44);
      send_pkt(3, 16'h0007, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      exp_pkt++;
      verify_pkt("post_rst", 3, 16'h0007, 8'h44);
      chk("post_rst_pkt_cnt",  134'(out_goe_pkt_cnt), 134'(stat_exp(exp_pkt)));
      chk("post_rst_drop_cnt", 134'(out_goe_drop_cnt), 134'(stat_exp(exp_drop)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
